// File: rtl/adc_host_pkg.sv
// Shared types and constants for the ADC host-side sequencer and its result FIFO.
package adc_host_pkg;

    localparam int RESULT_W = 16;
    localparam int CFG_W    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        CAPTURE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/adc_result_fifo.sv
// Small synchronous result FIFO with valid/ready read side and a full flag.
// A pop and a push in the same cycle are resolved pop-first, so a full FIFO
// can still accept a new word when the head is being consumed.
module adc_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);

    // Next pointers, occupancy and storage contents for this cycle's push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Register FIFO state; reset empties it and clears stored words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);
    // The head word reads as zero while empty so the output is clean after reset.
    assign data  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/adc_host_sequencer.sv
// System-clock-side sequencer for the SAR ADC: issues start pulses, freezes the
// config words for the duration of a conversion, synchronises the ADC's
// asynchronous finished level and queues results into a small FIFO.
module adc_host_sequencer
    import adc_host_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int START_CYCLES = 4,
    parameter int TIMEOUT_W    = 16,
    parameter int PERIOD_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_single,
    input  logic                cmd_continuous,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic [CFG_W-1:0]    cfg_word1_in,
    input  logic [CFG_W-1:0]    cfg_word2_in,
    output logic [CFG_W-1:0]    config_1_out,
    output logic [CFG_W-1:0]    config_2_out,
    output logic                start_conversion_out,
    input  logic                conversion_finished_in,
    input  logic [RESULT_W-1:0] result_in,
    output logic                res_valid,
    output logic [RESULT_W-1:0] res_data,
    input  logic                res_ready,
    output logic                busy,
    output logic                overflow,
    output logic                timeout,
    input  logic                clr_status
);

    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES + 1) : 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic                 start_q, start_d;
    logic [SCW-1:0]       start_cnt_q, start_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_inc;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [PERIOD_W-1:0]  period_dec;
    logic [PERIOD_W-1:0]  period_load;
    logic [CFG_W-1:0]     cfg1_q, cfg1_d;
    logic [CFG_W-1:0]     cfg2_q, cfg2_d;
    logic                 overflow_q, overflow_d;
    logic                 timeout_q, timeout_d;

    logic                 fin_meta_q;
    logic                 fin_sync_q;
    logic                 fin_prev_q;
    logic                 fin_rise;

    logic                 trigger;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_pop_ok;

    // Two-flop synchroniser for the asynchronous finished level, plus one more
    // flop to detect its rising edge in the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fin_meta_q <= 1'b0;
            fin_sync_q <= 1'b0;
            fin_prev_q <= 1'b0;
        end else begin
            fin_meta_q <= conversion_finished_in;
            fin_sync_q <= fin_meta_q;
            fin_prev_q <= fin_sync_q;
        end
    end

    assign fin_rise = fin_sync_q & ~fin_prev_q;

    // The trigger cycle itself is the first tick of the period, so loading
    // cfg_period-1 makes consecutive starts exactly cfg_period cycles apart.
    assign period_dec  = (period_q != '0) ? (period_q - PERIOD_W'(1)) : '0;
    assign period_load = (cfg_period != '0) ? (cfg_period - PERIOD_W'(1)) : '0;
    assign tmo_cnt_inc = (tmo_cnt_q != '1) ? (tmo_cnt_q + TIMEOUT_W'(1)) : tmo_cnt_q;

    assign trigger     = cmd_single || (cmd_continuous && (period_q == '0));
    assign fifo_pop_ok = res_valid && res_ready;

    // Sequencer next-state logic: trigger, start pulse timing, wait with
    // optional timeout, one-cycle result capture, and sticky status flags.
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        start_cnt_d = start_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        period_d    = period_dec;
        cfg1_d      = cfg1_q;
        cfg2_d      = cfg2_q;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;
        fifo_push   = 1'b0;

        // Clearing happens first so that a same-cycle event below re-sets the flag.
        if (clr_status) begin
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d     = START;
                    start_d     = 1'b1;
                    start_cnt_d = '0;
                    period_d    = period_load;
                    cfg1_d      = cfg_word1_in;
                    cfg2_d      = cfg_word2_in;
                end
            end

            START: begin
                if (start_cnt_q == START_LAST) begin
                    state_d   = WAIT_DONE;
                    start_d   = 1'b0;
                    tmo_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + SCW'(1);
                end
            end

            WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (fin_rise) begin
                    state_d = CAPTURE;
                end else if ((cfg_timeout != '0) && (tmo_cnt_inc == cfg_timeout)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end

            CAPTURE: begin
                fifo_push = 1'b1;
                if (fifo_full && !fifo_pop_ok) begin
                    overflow_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset aborts any conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            start_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            period_q    <= '0;
            cfg1_q      <= '0;
            cfg2_q      <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            start_cnt_q <= start_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            period_q    <= period_d;
            cfg1_q      <= cfg1_d;
            cfg2_q      <= cfg2_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

    adc_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (result_in),
        .pop       (res_ready),
        .valid     (res_valid),
        .data      (res_data),
        .full      (fifo_full)
    );

    assign config_1_out         = cfg1_q;
    assign config_2_out         = cfg2_q;
    assign start_conversion_out = start_q;
    assign busy                 = (state_q != IDLE);
    assign overflow             = overflow_q;
    assign timeout              = timeout_q;

endmodule

// File: tb/tb_adc_host_sequencer.sv
// Directed testbench for adc_host_sequencer with a simple behavioural ADC that
// answers each start pulse with a finished level and an incrementing result.
module tb_adc_host_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_single = 1'b0;
   logic        cmd_continuous = 1'b0;
   logic [15:0] cfg_period = 16'd0;
   logic [15:0] cfg_timeout = 16'd0;
   logic [15:0] cfg_word1_in = 16'd0;
   logic [15:0] cfg_word2_in = 16'd0;
   logic [15:0] config_1_out;
   logic [15:0] config_2_out;
   logic        start_conversion_out;
   logic        conversion_finished_in = 1'b0;
   logic [15:0] result_in = 16'd0;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_ready = 1'b0;
   logic        busy;
   logic        overflow;
   logic        timeout;
   logic        clr_status = 1'b0;

   int          checkCount = 0;
   int          failCount = 0;
   int          cyc = 0;

   logic        modelEnable = 1'b1;
   logic [15:0] modelBase = 16'd0;
   int          modelCount = 0;

   adc_host_sequencer #(
      .FIFO_DEPTH   (4),
      .START_CYCLES (4),
      .TIMEOUT_W    (16),
      .PERIOD_W     (16)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .cmd_single             (cmd_single),
      .cmd_continuous         (cmd_continuous),
      .cfg_period             (cfg_period),
      .cfg_timeout            (cfg_timeout),
      .cfg_word1_in           (cfg_word1_in),
      .cfg_word2_in           (cfg_word2_in),
      .config_1_out           (config_1_out),
      .config_2_out           (config_2_out),
      .start_conversion_out   (start_conversion_out),
      .conversion_finished_in (conversion_finished_in),
      .result_in              (result_in),
      .res_valid              (res_valid),
      .res_data               (res_data),
      .res_ready              (res_ready),
      .busy                   (busy),
      .overflow               (overflow),
      .timeout                (timeout),
      .clr_status             (clr_status)
   );

   // Free-running clock and cycle counter used for interval measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case a directed sequence ever stalls.
   always @(posedge clk) begin
      if (cyc > 30000) begin
         $display("[TB] FAIL watchdog: cycle %0d, expected completion before 30000", cyc);
         $fatal(1, "[TB] simulation stalled");
      end
   end

   // Behavioural ADC: drops finished on each start, raises it 40 cycles later
   // with the next result word unless disabled.
   always begin
      @(posedge start_conversion_out);
      conversion_finished_in = 1'b0;
      if (modelEnable) begin
         repeat (40) @(posedge clk);
         #1;
         if (modelEnable) begin
            result_in = modelBase + 16'(modelCount);
            modelCount = modelCount + 1;
            conversion_finished_in = 1'b1;
         end
      end
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle pulse on cmd_single and/or clr_status, aligned after a rising edge.
   task automatic applyStimulus(input logic singlePulse, input logic clrPulse);
      @(posedge clk);
      #1;
      cmd_single = singlePulse;
      clr_status = clrPulse;
      @(posedge clk);
      #1;
      cmd_single = 1'b0;
      clr_status = 1'b0;
   endtask

   task automatic waitIdle(input string tag);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      checkOutput(tag, 32'(busy), 32'd0);
   endtask

   task automatic waitStartFall(input string tag);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!start_conversion_out) break;
      end
      checkOutput(tag, 32'(start_conversion_out), 32'd0);
   endtask

   // Check the FIFO head against an expected word, then pop it.
   task automatic popCheck(input string tag, input logic [15:0] expected);
      @(negedge clk);
      checkOutput({tag, "_valid"}, 32'(res_valid), 32'd1);
      checkOutput(tag, 32'(res_data), 32'(expected));
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      int hiCount;
      int rises;
      int got;
      int extraRises;
      int riseCyc [5];
      logic [15:0] gotData [5];
      logic prevStart;

      $display("[TB] reset");
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_start", 32'(start_conversion_out), 32'd0);
      checkOutput("rst_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_data", 32'(res_data), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      checkOutput("rst_tmo", 32'(timeout), 32'd0);
      checkOutput("rst_cfg1", 32'(config_1_out), 32'd0);
      checkOutput("rst_cfg2", 32'(config_2_out), 32'd0);

      $display("[TB] test 1: single conversion");
      cfg_word1_in = 16'h0C25;
      cfg_word2_in = 16'h1234;
      modelBase = 16'h0ABC - 16'(modelCount);
      applyStimulus(1'b1, 1'b0);
      hiCount = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (start_conversion_out) hiCount++;
         else if (hiCount > 0) break;
      end
      checkOutput("t1_start_len", 32'(hiCount), 32'd4);
      checkOutput("t1_cfg1", 32'(config_1_out), 32'h0C25);
      checkOutput("t1_cfg2", 32'(config_2_out), 32'h1234);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (res_valid) break;
      end
      checkOutput("t1_busy_done", 32'(busy), 32'd0);
      popCheck("t1_data", 16'h0ABC);
      @(negedge clk);
      checkOutput("t1_empty", 32'(res_valid), 32'd0);

      $display("[TB] test 2: continuous mode");
      modelBase = 16'h1000 - 16'(modelCount);
      cfg_period = 16'd100;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_continuous = 1'b1;
      rises = 0;
      got = 0;
      prevStart = 1'b0;
      for (int k = 0; k < 1000 && got < 5; k++) begin
         @(negedge clk);
         if (start_conversion_out && !prevStart) begin
            if (rises < 5) riseCyc[rises] = cyc;
            rises++;
            if (rises == 5) cmd_continuous = 1'b0;
         end
         prevStart = start_conversion_out;
         if (res_valid && res_ready) begin
            if (got < 5) gotData[got] = res_data;
            got++;
         end
      end
      checkOutput("t2_results", 32'(got), 32'd5);
      checkOutput("t2_rises", 32'(rises), 32'd5);
      for (int i = 1; i < 5; i++) begin
         checkOutput($sformatf("t2_interval%0d", i), 32'(riseCyc[i] - riseCyc[i-1]), 32'd100);
      end
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("t2_data%0d", i), 32'(gotData[i]), 32'(16'h1000 + 16'(i)));
      end
      extraRises = 0;
      prevStart = start_conversion_out;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (start_conversion_out && !prevStart) extraRises++;
         prevStart = start_conversion_out;
      end
      checkOutput("t2_stopped", 32'(extraRises), 32'd0);
      checkOutput("t2_idle", 32'(busy), 32'd0);
      res_ready = 1'b0;
      cfg_period = 16'd0;

      $display("[TB] test 3: FIFO overflow and simultaneous pop/push");
      modelBase = 16'h2000 - 16'(modelCount);
      for (int n = 0; n < 5; n++) begin
         applyStimulus(1'b1, 1'b0);
         waitIdle($sformatf("t3_conv%0d_idle", n));
      end
      @(negedge clk);
      checkOutput("t3_ovf_set", 32'(overflow), 32'd1);
      checkOutput("t3_head", 32'(res_data), 32'h2000);
      checkOutput("t3_tmo_clear", 32'(timeout), 32'd0);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("t3_ovf_cleared", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         if (conversion_finished_in) break;
      end
      checkOutput("t3_fin_seen", 32'(conversion_finished_in), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      waitIdle("t3_conv5_idle");
      checkOutput("t3_popfirst_ovf", 32'(overflow), 32'd0);
      popCheck("t3_drain0", 16'h2001);
      popCheck("t3_drain1", 16'h2002);
      popCheck("t3_drain2", 16'h2003);
      popCheck("t3_drain3", 16'h2005);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      checkOutput("t3_empty_valid", 32'(res_valid), 32'd0);
      checkOutput("t3_empty_data", 32'(res_data), 32'd0);

      $display("[TB] test 4: timeout");
      modelEnable = 1'b0;
      cfg_timeout = 16'd50;
      applyStimulus(1'b1, 1'b0);
      waitStartFall("t4_start_fall");
      repeat (49) @(negedge clk);
      checkOutput("t4_tmo_before", 32'(timeout), 32'd0);
      checkOutput("t4_busy_before", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("t4_tmo_set", 32'(timeout), 32'd1);
      checkOutput("t4_busy_after", 32'(busy), 32'd0);
      checkOutput("t4_fifo_empty", 32'(res_valid), 32'd0);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("t4_tmo_cleared", 32'(timeout), 32'd0);
      cfg_timeout = 16'd0;
      modelEnable = 1'b1;

      $display("[TB] test 5: config words frozen during conversion");
      modelBase = 16'h5000 - 16'(modelCount);
      cfg_word2_in = 16'h8421;
      applyStimulus(1'b1, 1'b0);
      waitStartFall("t5_start_fall");
      cfg_word2_in = 16'h0000;
      repeat (5) @(negedge clk);
      checkOutput("t5_cfg2_wait", 32'(config_2_out), 32'h8421);
      waitIdle("t5_idle");
      checkOutput("t5_cfg2_done", 32'(config_2_out), 32'h8421);
      popCheck("t5_data0", 16'h5000);
      applyStimulus(1'b1, 1'b0);
      waitStartFall("t5_start_fall2");
      checkOutput("t5_cfg2_new", 32'(config_2_out), 32'h0000);
      waitIdle("t5_idle2");
      popCheck("t5_data1", 16'h5001);

      $display("[TB] test 6: reset during WAIT_DONE");
      cfg_word1_in = 16'h1111;
      applyStimulus(1'b1, 1'b0);
      waitStartFall("t6_start_fall");
      repeat (2) @(negedge clk);
      checkOutput("t6_busy_pre", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_start", 32'(start_conversion_out), 32'd0);
      checkOutput("t6_valid", 32'(res_valid), 32'd0);
      checkOutput("t6_data", 32'(res_data), 32'd0);
      checkOutput("t6_ovf", 32'(overflow), 32'd0);
      checkOutput("t6_tmo", 32'(timeout), 32'd0);
      checkOutput("t6_cfg1", 32'(config_1_out), 32'd0);
      checkOutput("t6_cfg2", 32'(config_2_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
